// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator at the head of the video pipeline.
// Produces hcount/vcount for the pixel generators, plus hsync/vsync/blank for
// the VGA output registers. Everything advances one pixel per pix_en_in tick.
// Sync/blank can be delayed by DELAY ticks to match downstream pixel latency.
// Optional feature macro: VGA_FRAME_COUNT_EN adds an 8-bit frame counter output.
// There is no FSM; the raster position itself (hcount_out/vcount_out) is the
// observable state. pix_en_in is a qualifier, not a handshake: the block never
// stalls it, and a low tick simply freezes all state except the start pulses.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int SYNC_POL = 0,
  parameter int DELAY    = 0
) (
  input  logic        clk_in,
  input  logic        rstn_in,
  input  logic        pix_en_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        line_start_out,
  output logic        frame_start_out
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]  frame_count_out
`endif
);

  // H_TOTAL must fit the 11-bit counter (<= 2048), V_TOTAL the 10-bit one (<= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  // Window bounds carried one bit wider so an end bound equal to the total
  // (zero back porch) cannot overflow.
  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG_W = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END_W = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG_W = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END_W = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  // Bundle order inside the delay line: {hsync, vsync, blank}.
  localparam logic [2:0] IDLE_BITS = {~SYNC_ACT, ~SYNC_ACT, 1'b1};

  // Raster decode for a given position.
  function automatic logic [2:0] decode(input logic [10:0] h, input logic [9:0] v);
    logic hs_win;
    logic vs_win;
    logic bl;
    hs_win = ({1'b0, h} >= HS_BEG_W) && ({1'b0, h} < HS_END_W);
    vs_win = ({1'b0, v} >= VS_BEG_W) && ({1'b0, v} < VS_END_W);
    bl     = ({1'b0, h} >= H_ACT_W) || ({1'b0, v} >= V_ACT_W);
    return {hs_win ? SYNC_ACT : ~SYNC_ACT, vs_win ? SYNC_ACT : ~SYNC_ACT, bl};
  endfunction

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_next;
  logic [9:0]  v_next;

  // pipe[0] is the undelayed decode aligned with the counters; pipe[DELAY]
  // drives the outputs.
  logic [2:0] pipe [0:DELAY];

  // Next raster position if this cycle carries a tick.
  always_comb begin
    h_wrap = (hcount_out == H_LAST);
    v_wrap = (vcount_out == V_LAST);
    h_next = h_wrap ? 11'd0 : hcount_out + 11'd1;
    v_next = vcount_out;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : vcount_out + 10'd1;
    end
  end

  // Counters, start pulses and the sync/blank delay line; reset wins over ticks.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      hcount_out      <= 11'd0;
      vcount_out      <= 10'd0;
      line_start_out  <= 1'b0;
      frame_start_out <= 1'b0;
      pipe[0]         <= decode(11'd0, 10'd0);
      for (int i = 1; i <= DELAY; i++) begin
        pipe[i] <= IDLE_BITS;
      end
    end else begin
      line_start_out  <= pix_en_in && h_wrap;
      frame_start_out <= pix_en_in && h_wrap && v_wrap;
      if (pix_en_in) begin
        hcount_out <= h_next;
        vcount_out <= v_next;
        pipe[0]    <= decode(h_next, v_next);
        for (int i = 1; i <= DELAY; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end
  end

  assign {hsync_out, vsync_out, blank_out} = pipe[DELAY];

`ifdef VGA_FRAME_COUNT_EN
  // Frame counter steps on the same edge that raises frame_start_out.
  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      frame_count_out <= 8'd0;
    end else if (pix_en_in && h_wrap && v_wrap) begin
      frame_count_out <= frame_count_out + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks vga_timing_gen against a tick-count model.
// Two instances share clock/reset/tick: the default 1024x768 timing (DELAY=0,
// active-low sync) and a tiny raster (15x10, DELAY=2, active-high sync) that
// wraps whole frames quickly.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn   = 1'b0;
  logic pix_en = 1'b0;

  logic [10:0] b_h;
  logic [9:0]  b_v;
  logic        b_hs, b_vs, b_bl, b_ls, b_fs;
  logic [10:0] s_h;
  logic [9:0]  s_v;
  logic        s_hs, s_vs, s_bl, s_ls, s_fs;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0]  b_fc, s_fc;
`endif

  vga_timing_gen dut_big (
    .clk_in(clk), .rstn_in(rstn), .pix_en_in(pix_en),
    .hcount_out(b_h), .vcount_out(b_v),
    .hsync_out(b_hs), .vsync_out(b_vs), .blank_out(b_bl),
    .line_start_out(b_ls), .frame_start_out(b_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count_out(b_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1), .DELAY(2)
  ) dut_small (
    .clk_in(clk), .rstn_in(rstn), .pix_en_in(pix_en),
    .hcount_out(s_h), .vcount_out(s_v),
    .hsync_out(s_hs), .vsync_out(s_vs), .blank_out(s_bl),
    .line_start_out(s_ls), .frame_start_out(s_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count_out(s_fc)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected {hsync, vsync, blank} after n ticks since reset, for a raster
  // described by its porch parameters, sync polarity and output delay.
  function automatic logic [2:0] exp_dec(input int n, input int ha, hfp, hs, hbp,
                                         va, vfp, vs, vbp, pol, dly);
    int ht, vt, m, h, v;
    logic act, hw, vw, bl;
    act = (pol != 0);
    if (n < dly) return {~act, ~act, 1'b1};
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    m  = n - dly;
    h  = m % ht;
    v  = (m / ht) % vt;
    hw = (h >= ha + hfp) && (h < ha + hfp + hs);
    vw = (v >= va + vfp) && (v < va + vfp + vs);
    bl = (h >= ha) || (v >= va);
    return {hw ? act : ~act, vw ? act : ~act, bl};
  endfunction

  // Model state: ticks since the last reset, and whether the last edge ticked.
  int   n        = 0;
  logic ticked   = 1'b0;
  logic seen_rst = 1'b0;
  int   fc_b     = 0;
  int   fc_s     = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      n <= 0; ticked <= 1'b0; seen_rst <= 1'b1; fc_b <= 0; fc_s <= 0;
    end else begin
      ticked <= pix_en;
      if (pix_en) begin
        n <= n + 1;
        if ((n + 1) % (1344 * 806) == 0) fc_b <= (fc_b + 1) % 256;
        if ((n + 1) % 150 == 0) fc_s <= (fc_s + 1) % 256;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    int hb, vb, hsm, vsm;
    logic [2:0] eb, es;
    if (seen_rst) begin
      hb  = n % 1344;
      vb  = (n / 1344) % 806;
      hsm = n % 15;
      vsm = (n / 15) % 10;
      eb  = exp_dec(n, 1024, 24, 136, 160, 768, 3, 6, 29, 0, 0);
      es  = exp_dec(n, 8, 2, 3, 2, 5, 1, 2, 2, 1, 2);
      chk("big_hcount", int'(b_h), hb);
      chk("big_vcount", int'(b_v), vb);
      chk("big_hsync", int'(b_hs), int'(eb[2]));
      chk("big_vsync", int'(b_vs), int'(eb[1]));
      chk("big_blank", int'(b_bl), int'(eb[0]));
      chk("big_line_start", int'(b_ls), int'(ticked && hb == 0));
      chk("big_frame_start", int'(b_fs), int'(ticked && hb == 0 && vb == 0));
      chk("small_hcount", int'(s_h), hsm);
      chk("small_vcount", int'(s_v), vsm);
      chk("small_hsync", int'(s_hs), int'(es[2]));
      chk("small_vsync", int'(s_vs), int'(es[1]));
      chk("small_blank", int'(s_bl), int'(es[0]));
      chk("small_line_start", int'(s_ls), int'(ticked && hsm == 0));
      chk("small_frame_start", int'(s_fs), int'(ticked && hsm == 0 && vsm == 0));
`ifdef VGA_FRAME_COUNT_EN
      chk("big_frame_count", int'(b_fc), fc_b);
      chk("small_frame_count", int'(s_fc), fc_s);
`endif
      if (ticked && hb == 0) exp_q.push_back(10'(vb));
      if (b_ls) begin
        if (exp_q.size() == 0) chk("ls_queue_unexpected", 1, 0);
        else chk("ls_queue_vcount", int'(b_v), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver / directed pins ----------------
  initial begin
    int ls_cnt;
    bit found;

    rstn = 1'b0; pix_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hcount", int'(b_h), 0);
    chk("rst_vcount", int'(b_v), 0);
    chk("rst_hsync", int'(b_hs), 1);
    chk("rst_vsync", int'(b_vs), 1);
    chk("rst_blank", int'(b_bl), 0);
    chk("rst_small_blank", int'(s_bl), 1);
    chk("rst_small_hsync", int'(s_hs), 0);

    // One full line at a tick per clock.
    rstn = 1'b1; pix_en = 1'b1; ls_cnt = 0;
    for (int i = 1; i <= 1344; i++) begin
      @(negedge clk);
      if (b_ls) ls_cnt++;
      case (i)
        1:    chk("small_blank_t1", int'(s_bl), 1);
        2:    chk("small_blank_t2", int'(s_bl), 0);
        11:   chk("small_hsync_t11", int'(s_hs), 0);
        12:   chk("small_hsync_t12", int'(s_hs), 1);
        91:   chk("small_vsync_t91", int'(s_vs), 0);
        92:   chk("small_vsync_t92", int'(s_vs), 1);
        150:  begin
                chk("small_fstart_t150", int'(s_fs), 1);
                chk("small_h_t150", int'(s_h), 0);
                chk("small_v_t150", int'(s_v), 0);
`ifdef VGA_FRAME_COUNT_EN
                chk("small_fc_t150", int'(s_fc), 1);
`endif
              end
        1023: chk("blank_1023", int'(b_bl), 0);
        1024: chk("blank_1024", int'(b_bl), 1);
        1047: begin
                chk("h_1047", int'(b_h), 1047);
                chk("hsync_1047", int'(b_hs), 1);
              end
        1048: chk("hsync_1048", int'(b_hs), 0);
        1183: chk("hsync_1183", int'(b_hs), 0);
        1184: chk("hsync_1184", int'(b_hs), 1);
        1343: chk("h_1343", int'(b_h), 1343);
        1344: begin
                chk("h_wrap", int'(b_h), 0);
                chk("v_wrap", int'(b_v), 1);
                chk("ls_wrap", int'(b_ls), 1);
              end
        default: ;
      endcase
    end
    chk("line_start_count", ls_cnt, 1);

    // Tick every third clock.
    for (int c = 0; c < 3000; c++) begin
      pix_en = (c % 3 == 0);
      @(negedge clk);
    end

    // Irregular ticks with occasional resets.
    for (int c = 0; c < 20000; c++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      rstn   = ($urandom_range(0, 2999) != 0);
      @(negedge clk);
    end

    // Reset mid-line at hcount=500, with the tick still high.
    rstn = 1'b1; pix_en = 1'b1; found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (b_h == 11'd500) found = 1'b1;
    end
    chk("reach_h500", int'(found), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_hcount", int'(b_h), 0);
    chk("midrst_vcount", int'(b_v), 0);
    chk("midrst_hsync", int'(b_hs), 1);
    chk("midrst_vsync", int'(b_vs), 1);
    chk("midrst_blank", int'(b_bl), 0);
    chk("midrst_small_blank", int'(s_bl), 1);

    rstn = 1'b1;
    for (int c = 0; c < 400; c++) begin
      pix_en = ($urandom_range(0, 1) != 0);
      @(negedge clk);
    end
    chk("ls_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator at the head of the video pipeline.
- Produces the hcount/vcount coordinates consumed by the sprite, box, cursor, colorpad and speed-bar pixel generators.
- Produces the matching hsync/vsync/blank for the VGA output registers.
- Advances one pixel per pixel-enable tick, so it can run on the system clock with a divided tick or on a dedicated pixel clock (tick tied high).
- Sync/blank can be delayed to match downstream pixel-generation latency.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels); H_TOTAL = sum of the four = 1344, must be <= 2048
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = 806, must be <= 1024
SYNC_POL, 0, sync active level (0 = active-low, as for 1024x768@60)
DELAY, 0, pixel ticks of extra delay on hsync/vsync/blank outputs (0..7)

Ports:
clk_in  input  1  system/pixel clock
rstn_in  input  1  one clock; reset is synchronous and active-low
pix_en_in  input  1  pixel tick; counters and delay line advance only when high
hcount_out  output  11  current pixel column, 0..H_TOTAL-1
vcount_out  output  10  current line, 0..V_TOTAL-1
hsync_out  output  1  horizontal sync, level per SYNC_POL
vsync_out  output  1  vertical sync, level per SYNC_POL
blank_out  output  1  high when outside the active area
line_start_out  output  1  one-clock pulse on the tick that enters hcount=0
frame_start_out  output  1  one-clock pulse on the tick that enters hcount=0, vcount=0

Behaviour:
- All outputs are registered; nothing changes on a cycle with pix_en_in=0 except the start pulses, which deassert after one clock.
- On a pix_en_in tick:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Undelayed decode, registered from next-state counter values so it is aligned with hcount_out/vcount_out at zero skew:
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
  - blank iff hcount >= H_ACTIVE or vcount >= V_ACTIVE.
- vsync changes only at hcount=0 transitions.
- DELAY>0: hsync/vsync/blank pass through a DELAY-deep shift register clocked on pix_en_in. hcount/vcount and the start pulses are not delayed.
- Reset (rstn_in=0 at a clock edge), from any state including mid-line:
  - hcount_out=0, vcount_out=0, start pulses=0.
  - hsync_out=vsync_out=~SYNC_POL (inactive).
  - With DELAY=0: blank_out=0, since (0,0) is active. Every delay stage resets to sync-inactive, blank=1, so with DELAY>0 blank_out=1 for DELAY ticks after reset.
- First tick after reset release moves to (1,0); no frame_start on that tick. frame_start first fires on the wrap after one full frame.
- Reset has priority over pix_en_in.
- pix_en_in may be irregular; counts depend only on the number of ticks, not on the cycles between them.

Optional Feature:
- Macro VGA_FRAME_COUNT_EN.
- When defined:
  - Adds output frame_count_out [7:0], incremented on each frame_start_out cycle, wrapping 255->0, reset to 0.
  - Used by animation blocks to pace motion.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then hold pix_en_in=1 for 1344 clocks:
  - hcount_out runs 0..1343 then returns to 0.
  - vcount_out goes 0->1 on that wrap.
  - line_start_out pulses exactly once.
- hsync window, default params: hsync_out=0 exactly for hcount_out 1048..1183, 1 elsewhere; blank_out=1 for hcount_out>=1024.
- Run one full frame (1344*806 ticks):
  - vsync_out=0 for vcount_out 771..776.
  - frame_start_out pulses once, when the counters return to (0,0).
  - With VGA_FRAME_COUNT_EN, frame_count_out goes 0->1.
- pix_en_in high every 3rd clock: hcount_out advances once per 3 clocks; outputs stable on the other cycles; line_start_out width is 1 clock.
- DELAY=2: hsync_out falls 2 ticks after hcount_out reaches 1048; blank_out=1 for the first 2 ticks after reset, then 0.
- Assert rstn_in low at (500,300) mid-frame: the next clock gives hcount_out=0, vcount_out=0, hsync_out=vsync_out=1, blank_out=0 (DELAY=0).
